// File: rtl/mdr_mem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdr_pkg
// Brief    : Shared size encodings, state type and defaults for mdr_mem_port.
// Revision : 1.0
// ============================================================================
package mdr_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   localparam int C_TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mdr_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : mdr_mem_port_if
// Brief    : Datapath and memory handshake bundle of the memory data register.
// Revision : 1.0
// ============================================================================
interface mdr_mem_port_if #(
   parameter int DATA_W = 32
);
   localparam int LANE_W = $clog2(DATA_W/8);

   logic                  enable;
   logic                  read;
   logic                  write;
   logic [1:0]            size;
   logic                  sign_ext;
   logic [LANE_W-1:0]     addr_lo;
   logic [DATA_W-1:0]     BusMuxOut;
   logic [DATA_W-1:0]     Mdatain;
   logic [DATA_W-1:0]     BusMuxIn;
   logic                  mem_req;
   logic                  mem_we;
   logic [DATA_W/8-1:0]   mem_be;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_ack;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output enable, read, write, size, sign_ext, addr_lo, BusMuxOut, Mdatain, mem_ack,
      input  BusMuxIn, mem_req, mem_we, mem_be, mem_wdata, busy, done, err
   );

   modport slave (
      input  enable, read, write, size, sign_ext, addr_lo, BusMuxOut, Mdatain, mem_ack,
      output BusMuxIn, mem_req, mem_we, mem_be, mem_wdata, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/mdr_mem_port_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mdr_lane_align
// Brief    : Byte-lane steering: read extract/extend, write replication, enables.
// Revision : 1.0
// ============================================================================
module mdr_lane_align
   import mdr_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANE_W = $clog2(DATA_W/8)
) (
   input  wire logic [1:0]          i_size,
   input  wire logic [LANE_W-1:0]   i_addr_lo,
   input  wire logic                i_sign_ext,
   input  wire logic [DATA_W-1:0]   i_q,
   input  wire logic [DATA_W-1:0]   i_rdata,
   output logic      [DATA_W-1:0]   o_rd_val,
   output logic      [DATA_W-1:0]   o_wdata,
   output logic      [DATA_W/8-1:0] o_be,
   output logic                     o_valid
);
   localparam int NB = DATA_W/8;

   int                w_nbytes;
   int                w_off;
   int                w_bits;
   logic              w_sb;
   logic [DATA_W-1:0] w_shift;

   always_comb begin
      w_nbytes = 1 << int'(i_size);
      w_off    = int'(i_addr_lo);
      w_bits   = (8 * w_nbytes > DATA_W) ? DATA_W : 8 * w_nbytes;
      w_shift  = i_rdata >> {i_addr_lo, 3'b000};
      w_sb     = 1'b0;
      o_valid  = 1'b0;
      o_rd_val = '0;
      o_wdata  = '0;
      o_be     = '0;

      case (i_size)
         SZ_BYTE:  o_valid = 1'b1;
         SZ_HALF:  o_valid = ~i_addr_lo[0];
         SZ_WORD:  o_valid = (i_addr_lo[1:0] == 2'b00);
         default:  o_valid = (DATA_W == 64) && (i_addr_lo == '0);
      endcase

      // Sign bit is the top bit of the selected field after lane shifting.
      for (int i = 0; i < DATA_W; i++) begin
         if (i == w_bits - 1) w_sb = i_sign_ext & w_shift[i];
      end
      for (int i = 0; i < DATA_W; i++) begin
         o_rd_val[i] = (i < w_bits) ? w_shift[i] : w_sb;
      end

      for (int i = 0; i < NB; i++) begin
         o_be[i] = (i >= w_off) && (i < w_off + w_nbytes);
         case (i_size)
            SZ_BYTE: o_wdata[8*i +: 8] = i_q[7:0];
            SZ_HALF: o_wdata[8*i +: 8] = i_q[8*(i%2) +: 8];
            SZ_WORD: o_wdata[8*i +: 8] = i_q[8*(i%4) +: 8];
            default: o_wdata[8*i +: 8] = i_q[8*i +: 8];
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mdr_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : mdr_mem_port
// Brief    : Memory data register with its own req/ack memory transactions.
// Revision : 1.0
// ============================================================================
module mdr_mem_port
   import mdr_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = C_TIMEOUT_DEF,
   parameter int LANE_W  = $clog2(DATA_W/8)
) (
   input  wire logic       clock,
   input  wire logic       clear,
   mdr_mem_port_if.slave   bus
);
   localparam int                CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_W-1:0]     r_q;
   logic                  r_req;
   logic                  r_we;
   logic [DATA_W/8-1:0]   r_be;
   logic [DATA_W-1:0]     r_wdata;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic [1:0]            r_size;
   logic [LANE_W-1:0]     r_off;
   logic                  r_sext;

   logic [1:0]            w_size;
   logic [LANE_W-1:0]     w_off;
   logic                  w_sext;
   logic [DATA_W-1:0]     w_rd_val;
   logic [DATA_W-1:0]     w_wdata;
   logic [DATA_W/8-1:0]   w_be;
   logic                  w_valid;

   // Live inputs steer the command decode; latched ones steer the read return.
   assign w_size = (r_state == ST_IDLE) ? bus.size     : r_size;
   assign w_off  = (r_state == ST_IDLE) ? bus.addr_lo  : r_off;
   assign w_sext = (r_state == ST_IDLE) ? bus.sign_ext : r_sext;

   mdr_lane_align #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_align (
      .i_size     (w_size),
      .i_addr_lo  (w_off),
      .i_sign_ext (w_sext),
      .i_q        (r_q),
      .i_rdata    (bus.Mdatain),
      .o_rd_val   (w_rd_val),
      .o_wdata    (w_wdata),
      .o_be       (w_be),
      .o_valid    (w_valid)
   );

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_q     <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_size  <= SZ_BYTE;
         r_off   <= '0;
         r_sext  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.read || bus.write) begin
                  if (w_valid) begin
                     r_state <= bus.read ? ST_RD_WAIT : ST_WR_WAIT;
                     r_req   <= 1'b1;
                     r_we    <= ~bus.read;
                     r_be    <= w_be;
                     r_wdata <= bus.read ? '0 : w_wdata;
                     r_busy  <= 1'b1;
                     r_err   <= 1'b0;
                     r_cnt   <= '0;
                     r_size  <= bus.size;
                     r_off   <= bus.addr_lo;
                     r_sext  <= bus.sign_ext;
                  end else begin
                     r_done <= 1'b1;
                     r_err  <= 1'b1;
                  end
               end else if (bus.enable) begin
                  r_q <= bus.BusMuxOut;
               end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
               if (bus.mem_ack || r_cnt == C_CNT_LAST) begin
                  if (bus.mem_ack && r_state == ST_RD_WAIT) r_q <= w_rd_val;
                  r_state <= ST_IDLE;
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_be    <= '0;
                  r_wdata <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_err   <= ~bus.mem_ack;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.BusMuxIn  = r_q;
   assign bus.mem_req   = r_req;
   assign bus.mem_we    = r_we;
   assign bus.mem_be    = r_be;
   assign bus.mem_wdata = r_wdata;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdr_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdr_mem_port
// Brief    : Directed self-checking bench for mdr_mem_port (DATA_W=32).
// Revision : 1.0
// ============================================================================
module tb_mdr_mem_port;
   import mdr_pkg::*;

   logic clock;
   logic clear;
   int   n_pass;
   int   n_total;

   mdr_mem_port_if #(.DATA_W(32)) bus ();

   mdr_mem_port #(
      .DATA_W  (32),
      .TIMEOUT (15)
   ) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      clear = 1'b1;
      bus.enable = 0; bus.read = 0; bus.write = 0; bus.size = SZ_BYTE;
      bus.sign_ext = 0; bus.addr_lo = 0; bus.BusMuxOut = 0; bus.Mdatain = 0;
      bus.mem_ack = 0;
      step(); step();
      chk("rst_q", bus.BusMuxIn, 0);
      chk("rst_req", bus.mem_req, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      clear = 1'b0;
      step();

      // Load from bus
      bus.enable = 1; bus.BusMuxOut = 32'hDEADBEEF;
      step();
      bus.enable = 0;
      chk("en_q", bus.BusMuxIn, 32'hDEADBEEF);
      chk("en_done", bus.done, 0);

      // Ack while idle is ignored
      bus.mem_ack = 1;
      step();
      bus.mem_ack = 0;
      chk("idle_ack_done", bus.done, 0);

      // Signed byte read, lane 2, ack on third wait cycle
      bus.read = 1; bus.size = SZ_BYTE; bus.addr_lo = 2; bus.sign_ext = 1;
      bus.Mdatain = 32'h1285FF00;
      step();
      bus.read = 0;
      chk("rb_req", bus.mem_req, 1);
      chk("rb_busy", bus.busy, 1);
      chk("rb_be", bus.mem_be, 4'h4);
      chk("rb_we", bus.mem_we, 0);
      bus.sign_ext = 0;  // latched at command, must not matter now
      step(); step();
      bus.mem_ack = 1;
      step();
      bus.mem_ack = 0;
      chk("rb_q_sx", bus.BusMuxIn, 32'hFFFFFF85);
      chk("rb_done", bus.done, 1);
      chk("rb_req_off", bus.mem_req, 0);
      chk("rb_err", bus.err, 0);
      step();
      chk("rb_done_pulse", bus.done, 0);

      // Zero-extended byte read with minimum latency
      bus.read = 1; bus.sign_ext = 0;
      step();
      bus.read = 0; bus.mem_ack = 1;
      step();
      bus.mem_ack = 0;
      chk("rbz_q", bus.BusMuxIn, 32'h00000085);
      chk("rbz_done", bus.done, 1);

      // Half write at lane 2
      bus.enable = 1; bus.BusMuxOut = 32'h0000ABCD;
      step();
      bus.enable = 0;
      bus.write = 1; bus.size = SZ_HALF; bus.addr_lo = 2;
      step();
      bus.write = 0;
      chk("wh_req", bus.mem_req, 1);
      chk("wh_we", bus.mem_we, 1);
      chk("wh_be", bus.mem_be, 4'hC);
      chk("wh_wdata", bus.mem_wdata, 32'hABCDABCD);
      bus.mem_ack = 1;
      step();
      bus.mem_ack = 0;
      chk("wh_done", bus.done, 1);
      chk("wh_q", bus.BusMuxIn, 32'h0000ABCD);
      chk("wh_we_off", bus.mem_we, 0);
      chk("wh_be_off", bus.mem_be, 0);

      // Misaligned word, then dword at 32-bit width
      bus.read = 1; bus.size = SZ_WORD; bus.addr_lo = 1;
      step();
      bus.read = 0;
      chk("mis_req", bus.mem_req, 0);
      chk("mis_err", bus.err, 1);
      chk("mis_done", bus.done, 1);
      chk("mis_q", bus.BusMuxIn, 32'h0000ABCD);
      step();
      chk("mis_done_pulse", bus.done, 0);
      chk("mis_err_held", bus.err, 1);
      bus.read = 1; bus.size = SZ_DWORD; bus.addr_lo = 0;
      step();
      bus.read = 0;
      chk("dw_req", bus.mem_req, 0);
      chk("dw_done", bus.done, 1);
      chk("dw_err", bus.err, 1);
      step();

      // Asynchronous clear in the middle of a read
      bus.read = 1; bus.size = SZ_WORD; bus.addr_lo = 0;
      step();
      bus.read = 0;
      chk("clr_pre_req", bus.mem_req, 1);
      #2 clear = 1'b1;
      #1;
      chk("clr_req", bus.mem_req, 0);
      chk("clr_busy", bus.busy, 0);
      chk("clr_q", bus.BusMuxIn, 0);
      chk("clr_err", bus.err, 0);
      #1 clear = 1'b0;
      step();
      chk("clr_done", bus.done, 0);

      // Timeout with no ack
      bus.enable = 1; bus.BusMuxOut = 32'h13572468;
      step();
      bus.enable = 0;
      bus.read = 1; bus.size = SZ_WORD; bus.addr_lo = 0; bus.Mdatain = 32'hCAFEF00D;
      step();
      bus.read = 0;
      for (int k = 0; k < 14; k++) step();
      chk("to_req_last", bus.mem_req, 1);
      chk("to_done_early", bus.done, 0);
      step();
      chk("to_req", bus.mem_req, 0);
      chk("to_busy", bus.busy, 0);
      chk("to_done", bus.done, 1);
      chk("to_err", bus.err, 1);
      chk("to_q", bus.BusMuxIn, 32'h13572468);

      // Read and write together: read wins, err clears (accepted on done cycle)
      bus.read = 1; bus.write = 1;
      step();
      bus.read = 0; bus.write = 0;
      chk("rw_we", bus.mem_we, 0);
      chk("rw_err", bus.err, 0);
      chk("rw_req", bus.mem_req, 1);
      bus.mem_ack = 1;
      step();
      bus.mem_ack = 0;
      chk("rw_q", bus.BusMuxIn, 32'hCAFEF00D);
      chk("rw_done", bus.done, 1);
      chk("rw_err_after", bus.err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
